// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame transmitter.
package can_pkg;

  localparam int CRC_W   = 15;
  localparam int ID_LEN  = 11;
  localparam int DLC_LEN = 4;
  localparam int CRC_LEN = 15;

  localparam logic [CRC_W-1:0] CRC_POLY_DEF = 15'h4599;

  // S_START: frame latched, line still recessive until the next bit_en drives SOF.
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA,
    S_CRC, S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS
  } tx_state_e;

  // Number of data-field bits: remote frames carry none, DLC above 8 caps at 8 bytes.
  function automatic logic [6:0] data_bits(input logic rtr, input logic [3:0] dlc);
    if (rtr) return 7'd0;
    if (dlc > 4'd8) return 7'd64;
    return {dlc, 3'b000};
  endfunction

endpackage

// File: rtl/can_crc15_gen.sv
// Serial CRC-15 generator fed one unstuffed bit per enable; the top reads the
// finished register MSB first to send the CRC field.
module can_crc15_gen
  import can_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q;

  // Shift in one bit; clear restarts the sum for a new frame.
  always_ff @(posedge clk) begin
    if (rst || clr) crc_q <= '0;
    else if (en)    crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ ((din ^ crc_q[CRC_W-1]) ? POLY : '0);
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0A frame serialiser: field sequencing, bit stuffing, CRC append,
// arbitration / bit-error / ACK monitoring. Bit timing comes from external strobes.
module can_frame_tx
  import can_pkg::*;
#(
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEF,
  parameter int               EOF_BITS = 7,
  parameter int               IFS_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [10:0] frame_id,
  input  logic        frame_rtr,
  input  logic [3:0]  frame_dlc,
  input  logic [63:0] frame_data,
  input  logic        bit_en,
  input  logic        sample_en,
  input  logic        can_rx,
  output logic        can_tx,
  output logic        busy,
  output logic        tx_done,
  output logic        arb_lost,
  output logic        bit_err,
  output logic        ack_err
);

  tx_state_e   state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;      // bit index within the current field
  logic        stuff_q, stuff_d;  // wire bit is a stuff bit
  logic [2:0]  run_q, run_d;      // consecutive equal levels driven
  logic        tx_q, tx_d;
  logic        done_q, done_d, arb_q, arb_d, berr_q, berr_d, aerr_q, aerr_d;

  logic [10:0] id_q;
  logic        rtr_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic [6:0]  nbits_q;

  logic [CRC_W-1:0] crc;
  logic             crc_clr, crc_en, crc_din;
  logic             accept;

  // Successor of the current field bit.
  tx_state_e   nxt_state;
  logic [6:0]  nxt_cnt;
  logic        nxt_bit, nxt_crc;

  logic [3:0] id_idx, crc_idx;
  logic [1:0] dlc_idx;
  logic [5:0] dat_idx;

  assign id_idx  = 4'd9  - cnt_q[3:0];
  assign dlc_idx = 2'd2  - cnt_q[1:0];
  assign dat_idx = 6'd62 - cnt_q[5:0];
  assign crc_idx = 4'd13 - cnt_q[3:0];

  assign frame_ready = (state_q == S_IDLE);
  assign accept      = frame_ready && frame_valid;

  can_crc15_gen #(.POLY(CRC_POLY)) u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc)
  );

  // Field sequencer: which field bit follows the one last sent, and whether it feeds the CRC.
  always_comb begin
    nxt_state = state_q;
    nxt_cnt   = '0;
    nxt_bit   = 1'b1;
    nxt_crc   = 1'b0;
    case (state_q)
      S_START: begin nxt_state = S_SOF; nxt_bit = 1'b0; nxt_crc = 1'b1; end
      S_SOF:   begin nxt_state = S_ID;  nxt_bit = id_q[10]; nxt_crc = 1'b1; end
      S_ID: begin
        nxt_crc = 1'b1;
        if (cnt_q == 7'(ID_LEN-1)) begin nxt_state = S_RTR; nxt_bit = rtr_q; end
        else begin nxt_cnt = cnt_q + 7'd1; nxt_bit = id_q[id_idx]; end
      end
      S_RTR: begin nxt_state = S_IDE; nxt_bit = 1'b0; nxt_crc = 1'b1; end
      S_IDE: begin nxt_state = S_R0;  nxt_bit = 1'b0; nxt_crc = 1'b1; end
      S_R0:  begin nxt_state = S_DLC; nxt_bit = dlc_q[3]; nxt_crc = 1'b1; end
      S_DLC: begin
        if (cnt_q != 7'(DLC_LEN-1)) begin
          nxt_cnt = cnt_q + 7'd1; nxt_bit = dlc_q[dlc_idx]; nxt_crc = 1'b1;
        end else if (nbits_q != 7'd0) begin
          nxt_state = S_DATA; nxt_bit = data_q[63]; nxt_crc = 1'b1;
        end else begin
          nxt_state = S_CRC; nxt_bit = crc[CRC_W-1];
        end
      end
      S_DATA: begin
        if (cnt_q == nbits_q - 7'd1) begin nxt_state = S_CRC; nxt_bit = crc[CRC_W-1]; end
        else begin nxt_cnt = cnt_q + 7'd1; nxt_bit = data_q[dat_idx]; nxt_crc = 1'b1; end
      end
      S_CRC: begin
        if (cnt_q == 7'(CRC_LEN-1)) nxt_state = S_CRC_DEL;
        else begin nxt_cnt = cnt_q + 7'd1; nxt_bit = crc[crc_idx]; end
      end
      S_CRC_DEL:  nxt_state = S_ACK_SLOT;
      S_ACK_SLOT: nxt_state = S_ACK_DEL;
      S_ACK_DEL:  nxt_state = S_EOF;
      S_EOF: begin
        if (cnt_q == 7'(EOF_BITS-1)) nxt_state = (IFS_BITS > 1) ? S_IFS : S_IDLE;
        else nxt_cnt = cnt_q + 7'd1;
      end
      // The IDLE transition happens at the start of the last IFS bit, so a
      // held request drives SOF only after IFS_BITS recessive bit times.
      S_IFS: begin
        if (cnt_q == 7'(IFS_BITS-2)) nxt_state = S_IDLE;
        else nxt_cnt = cnt_q + 7'd1;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Main control: sample check first, then bit_en advance (stuff bit or next field bit).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stuff_d = stuff_q;
    run_d   = run_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    arb_d   = 1'b0;
    berr_d  = 1'b0;
    aerr_d  = 1'b0;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = 1'b0;
    if (state_q == S_IDLE) begin
      if (accept) begin
        state_d = S_START;
        cnt_d   = '0;
        stuff_d = 1'b0;
        run_d   = '0;
        crc_clr = 1'b1;
      end
    end else begin
      if (sample_en && state_q != S_START && state_q != S_IFS) begin
        if (!stuff_q && (state_q == S_ID || state_q == S_RTR)) arb_d = tx_q && !can_rx;
        else if (state_q == S_ACK_SLOT) aerr_d = can_rx;
        else berr_d = (can_rx != tx_q);
      end
      if (arb_d || berr_d || aerr_d) begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end else if (bit_en) begin
        if (state_q inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC}
            && run_q == 3'd5) begin
          tx_d    = ~tx_q;
          run_d   = 3'd1;
          stuff_d = 1'b1;
        end else begin
          state_d = nxt_state;
          cnt_d   = nxt_cnt;
          tx_d    = nxt_bit;
          stuff_d = 1'b0;
          run_d   = (nxt_bit == tx_q) ? ((run_q == 3'd7) ? run_q : run_q + 3'd1) : 3'd1;
          crc_en  = nxt_crc;
          crc_din = nxt_bit;
          done_d  = (state_q == S_EOF) && (cnt_q == 7'(EOF_BITS-1));
        end
      end
    end
  end

  // State, line driver and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stuff_q <= 1'b0;
      run_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      arb_q   <= 1'b0;
      berr_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stuff_q <= stuff_d;
      run_q   <= run_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      arb_q   <= arb_d;
      berr_q  <= berr_d;
      aerr_q  <= aerr_d;
    end
  end

  // Frame fields captured on acceptance and held for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= '0;
      rtr_q   <= 1'b0;
      dlc_q   <= '0;
      data_q  <= '0;
      nbits_q <= '0;
    end else if (accept) begin
      id_q    <= frame_id;
      rtr_q   <= frame_rtr;
      dlc_q   <= frame_dlc;
      data_q  <= frame_data;
      nbits_q <= data_bits(frame_rtr, frame_dlc);
    end
  end

  assign can_tx   = tx_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_done  = done_q;
  assign arb_lost = arb_q;
  assign bit_err  = berr_q;
  assign ack_err  = aerr_q;

endmodule
